kb_scan_filter: RTL and testbench

Upstream neighbour of the scan-code-to-ASCII converter. Consumes raw bytes from the PS/2 receiver (rx_done_tick/rx_data) and strips make/break protocol framing. Emits exactly one 8-bit scan code per completed keystroke, taken on key release, so typematic repeats are suppressed. Codes are buffered in a small first-word-fall-through FIFO that the consumer pops with rd_key.

---
 rtl/kb_pkg.sv | 12 +
 rtl/kb_fifo.sv | 57 +++++
 rtl/kb_scan_filter.sv | 82 ++++++++
 tb/tb_kb_scan_filter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared constants for the PS/2 scan-code filter: protocol prefix bytes and FSM encoding.
package kb_pkg;

   localparam logic [7:0] BRK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BRK     = 2'd1;
   localparam logic [1:0] ST_EXT     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

endpackage

// File: rtl/kb_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head entry is always on r_data.
module kb_fifo #(
   parameter int B = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr,
   input  logic         rd,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full
);

   localparam logic [W:0] DEPTH = (W+1)'(1) << W;

   logic [B-1:0] r_mem [2**W];
   logic [W-1:0] r_wptr;
   logic [W-1:0] r_rptr;
   logic [W:0]   r_count;
   logic         w_do_rd;
   logic         w_do_wr;

   assign empty = (r_count == '0);
   assign full  = (r_count == DEPTH);

   // A pop on empty is ignored; a push on full is only accepted alongside a real pop.
   assign w_do_rd = rd & ~empty;
   assign w_do_wr = wr & (~full | w_do_rd);

   assign r_data = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_do_wr)
         r_mem[r_wptr] <= w_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_do_rd)
            r_rptr <= r_rptr + 1'b1;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/kb_scan_filter.sv
// Strips PS/2 make/break framing and queues one scan code per key release.
module kb_scan_filter
   import kb_pkg::*;
#(
   parameter int W_SIZE = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       rd_key,
   output logic [7:0] key_code,
   output logic       kb_empty,
   output logic       kb_full,
   output logic       overflow
);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       w_push;
   logic [7:0] w_head;
   logic       r_overflow;

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      if (rx_done_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (rx_data == BRK_CODE)
                  w_state_nxt = ST_BRK;
               else if (rx_data == EXT_CODE)
                  w_state_nxt = ST_EXT;
            end
            ST_BRK: begin
               // A stray prefix inside a break sequence resyncs instead of queueing.
               if (rx_data != BRK_CODE && rx_data != EXT_CODE) begin
                  w_state_nxt = ST_IDLE;
                  w_push      = 1'b1;
               end
            end
            ST_EXT: begin
               if (rx_data == BRK_CODE)
                  w_state_nxt = ST_EXT_BRK;
               else if (rx_data != EXT_CODE)
                  w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Full FIFO only drops the code when no pop frees a slot this cycle.
         if (w_push && kb_full && !rd_key)
            r_overflow <= 1'b1;
      end
   end

   kb_fifo #(
      .B (8),
      .W (W_SIZE)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (w_push),
      .rd      (rd_key),
      .w_data  (rx_data),
      .r_data  (w_head),
      .empty   (kb_empty),
      .full    (kb_full)
   );

   assign key_code = kb_empty ? 8'h00 : w_head;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_kb_scan_filter.sv
// Scoreboard bench for kb_scan_filter: expected codes queued at stimulus, checked on pop.
module tb_kb_scan_filter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rd_key;
   logic [7:0] key_code;
   logic       kb_empty;
   logic       kb_full;
   logic       overflow;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   kb_scan_filter #(.W_SIZE(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .rd_key       (rd_key),
      .key_code     (key_code),
      .kb_empty     (kb_empty),
      .kb_full      (kb_full),
      .overflow     (overflow)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change #1 after a rising edge; outputs are sampled there too.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic tick(input logic [7:0] b);
      rx_done_tick = 1'b1;
      rx_data      = b;
      cyc();
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
   endtask

   task automatic key(input logic [7:0] b, input bit expect_q);
      tick(b);
      tick(8'hF0);
      tick(b);
      if (expect_q) exp_q.push_back(b);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_empty"}, 8'(kb_empty), 8'd1);
      chk({tag, "_code"},  key_code,     8'h00);
      chk({tag, "_full"},  8'(kb_full),  8'd0);
   endtask

   task automatic pop_one(input string tag);
      logic [7:0] e;
      e = exp_q.pop_front();
      chk({tag, "_nempty"}, 8'(kb_empty), 8'd0);
      chk({tag, "_code"},   key_code,     e);
      rd_key = 1'b1;
      cyc();
      rd_key = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) pop_one(tag);
      check_idle_outputs({tag, "_drained"});
   endtask

   initial begin
      reset_n      = 1'b0;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      rd_key       = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
      check_idle_outputs("rst");
      chk("rst_ovf", 8'(overflow), 8'd0);

      // 1: basic keystroke, visible one cycle after final tick
      tick(8'h1C);
      tick(8'hF0);
      chk("t1_pre_empty", 8'(kb_empty), 8'd1);
      tick(8'h1C);
      exp_q.push_back(8'h1C);
      drain("t1");

      // 2: typematic repeats collapse to one code; pop on empty is harmless
      tick(8'h1C); tick(8'h1C); tick(8'h1C);
      key(8'h1C, 1'b1);
      drain("t2");
      rd_key = 1'b1;
      cyc();
      rd_key = 1'b0;
      check_idle_outputs("t2_rd_empty");
      key(8'h15, 1'b1);
      drain("t2_after");

      // 3: noise, extended make, extended break all discarded
      tick(8'hAA);
      tick(8'hE0); tick(8'h75);
      tick(8'hE0); tick(8'hF0); tick(8'h75);
      tick(8'hFA);
      check_idle_outputs("t3_noise");
      key(8'h16, 1'b1);
      drain("t3");

      // malformed break: F0 F0 E0 then code still queues the code
      tick(8'hF0); tick(8'hF0); tick(8'hE0); tick(8'h4D);
      exp_q.push_back(8'h4D);
      drain("malf");

      // 4: overflow drops the fifth code
      key(8'h16, 1'b1);
      key(8'h1E, 1'b1);
      key(8'h26, 1'b1);
      key(8'h25, 1'b1);
      chk("t4_full_pre", 8'(kb_full),  8'd1);
      chk("t4_ovf_pre",  8'(overflow), 8'd0);
      key(8'h2E, 1'b0);
      chk("t4_full", 8'(kb_full),  8'd1);
      chk("t4_ovf",  8'(overflow), 8'd1);
      drain("t4");
      chk("t4_ovf_sticky", 8'(overflow), 8'd1);

      // 5: full with simultaneous pop and push
      do_reset();
      chk("t5_ovf_rst", 8'(overflow), 8'd0);
      key(8'h16, 1'b1);
      key(8'h1E, 1'b1);
      key(8'h26, 1'b1);
      key(8'h25, 1'b1);
      tick(8'h2E);
      tick(8'hF0);
      chk("t5_head", key_code, exp_q.pop_front());
      rx_done_tick = 1'b1;
      rx_data      = 8'h2E;
      rd_key       = 1'b1;
      cyc();
      rx_done_tick = 1'b0;
      rd_key       = 1'b0;
      exp_q.push_back(8'h2E);
      chk("t5_full", 8'(kb_full),  8'd1);
      chk("t5_ovf",  8'(overflow), 8'd0);
      drain("t5");

      // 6: reset mid-sequence aborts it and returns FSM to IDLE
      tick(8'h1C);
      tick(8'hF0);
      do_reset();
      tick(8'h1C);
      check_idle_outputs("t6");
      chk("t6_ovf", 8'(overflow), 8'd0);
      key(8'h1C, 1'b1);
      drain("t6_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
